// File: rtl/vga_pkg.sv
// Shared VGA timing constants, framebuffer geometry and the CPU port state type.
package vga_pkg;

   localparam int H_TOTAL        = 800;
   localparam int V_TOTAL        = 525;
   localparam int H_ACTIVE       = 640;
   localparam int V_ACTIVE       = 480;
   localparam int H_ACTIVE_START = 144;
   localparam int V_ACTIVE_START = 35;

   // 320x240 framebuffer, four 3-bit pixels per 12-bit word
   localparam int FB_WORDS_PER_LINE = 80;
   localparam int FB_WORDS          = 19200;

   // ACCESS is the cycle the RAM carries the CPU request, ACK the cycle after
   typedef enum logic [1:0] {
      CPU_IDLE   = 2'd0,
      CPU_ACCESS = 2'd1,
      CPU_ACK    = 2'd2
   } cpu_state_t;

endpackage

// File: rtl/pixel_shifter.sv
// Serialises a 12-bit framebuffer word into four 3-bit pixels, each held for
// two pixel clocks (the 2x horizontal scale).
module pixel_shifter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [11:0] load_data,
   output logic [2:0]  pixel
);

   logic [11:0] shift_q;
   logic        second_q;   // current pixel has already been shown for one clock

   // The new word is visible in its own load cycle so pixel 0 is not delayed.
   assign pixel = load ? load_data[11:9] : shift_q[11:9];

   // Load a word, or advance to the next pixel after every second clock.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (!rst_n) begin
         shift_q  <= '0;
         second_q <= 1'b0;
      end else if (load) begin
         shift_q  <= load_data;
         second_q <= 1'b1;
      end else if (second_q) begin
         shift_q  <= {shift_q[8:0], 3'b000};
         second_q <= 1'b0;
      end else begin
         second_q <= 1'b1;
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Shares a single-port synchronous-read VRAM between display fetch (fixed
// priority) and a CPU port, and drives the registered RGB pixel outputs.
module vram_arbiter #(
   parameter int H_ACTIVE_START = vga_pkg::H_ACTIVE_START,
   parameter int V_ACTIVE_START = vga_pkg::V_ACTIVE_START,
   parameter int ADDR_W         = 15,
   parameter int DATA_W         = 12
) (
   input  logic              clk25175KHz,
   input  logic              reset,
   input  logic [9:0]        hcount,
   input  logic [9:0]        vcount,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] vram_addr,
   output logic              vram_we,
   output logic [DATA_W-1:0] vram_wdata,
   input  logic [DATA_W-1:0] vram_rdata,
   output logic              redOut,
   output logic              greenOut,
   output logic              blueOut
);

   import vga_pkg::*;

   localparam logic [9:0] H_FIRST    = 10'(H_ACTIVE_START);
   localparam logic [9:0] H_LAST     = 10'(H_ACTIVE_START + H_ACTIVE - 1);
   localparam logic [9:0] V_FIRST    = 10'(V_ACTIVE_START);
   localparam logic [9:0] V_LAST     = 10'(V_ACTIVE_START + V_ACTIVE - 1);
   // Fetch runs one word (8 clocks) ahead of the pixels it feeds
   localparam logic [9:0] SLOT_FIRST = 10'(H_ACTIVE_START - 8);
   localparam logic [9:0] SLOT_LAST  = 10'(H_ACTIVE_START + H_ACTIVE - 16);
   localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_WORDS);

   logic              h_active, v_active, active;
   logic              slot, load, grant, in_range;
   logic [2:0]        slot_phase, pix_phase;
   logic [6:0]        word_idx;
   logic [8:0]        line;
   logic [ADDR_W-1:0] disp_addr;
   cpu_state_t        state_q, cur_state, next_state;
   logic              rd_valid_q, slot_q;
   logic [DATA_W-1:0] hold_q;
   logic [2:0]        pixel, rgb_q;

   // Raster decode: all slots and load points are pure functions of the counts.
   assign h_active   = (hcount >= H_FIRST) && (hcount <= H_LAST);
   assign v_active   = (vcount >= V_FIRST) && (vcount <= V_LAST);
   assign active     = h_active && v_active;
   assign slot_phase = 3'(hcount - SLOT_FIRST);
   assign word_idx   = 7'((hcount - SLOT_FIRST) >> 3);
   assign slot       = v_active && (hcount >= SLOT_FIRST) && (hcount <= SLOT_LAST)
                       && (slot_phase == 3'd0);
   assign pix_phase  = 3'(hcount - H_FIRST);
   assign load       = active && (pix_phase == 3'd0);

   // Each framebuffer line is shown on two display lines; line*80 = (line<<6)+(line<<4).
   assign line      = 9'((vcount - V_FIRST) >> 1);
   assign disp_addr = ADDR_W'({line, 6'b0}) + ADDR_W'({line, 4'b0}) + ADDR_W'(word_idx);

   assign in_range = cpu_addr < FB_LIMIT;

   // CPU grant and RAM request mux; a grant makes this cycle the ACCESS cycle.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      grant      = (state_q == CPU_IDLE) && cpu_req && !slot;
      cur_state  = grant ? CPU_ACCESS : state_q;
      next_state = CPU_IDLE;
      vram_addr  = '0;
      vram_we    = 1'b0;
      vram_wdata = '0;
      case (cur_state)
         CPU_ACCESS: next_state = CPU_ACK;
         CPU_ACK:    next_state = CPU_IDLE;
         default:    next_state = CPU_IDLE;
      endcase
      if (slot) begin
         vram_addr = disp_addr;
      end else if (cur_state == CPU_ACCESS && in_range) begin
         // Out-of-range accesses leave the RAM idle but are still acked
         vram_addr  = cpu_addr;
         vram_we    = cpu_we;
         vram_wdata = cpu_wdata;
      end
   end

   // CPU state register plus a flag telling the ACK cycle whether to pass read data.
   always_ff @(posedge clk25175KHz or negedge reset) begin
      if (!reset) begin
         state_q    <= CPU_IDLE;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= next_state;
         rd_valid_q <= grant && !cpu_we && in_range;
      end
   end

   assign cpu_ack   = (state_q == CPU_ACK);
   assign cpu_rdata = (cpu_ack && rd_valid_q) ? vram_rdata : '0;

   // Capture the display word the cycle after its fetch slot.
   always_ff @(posedge clk25175KHz or negedge reset) begin
      if (!reset) begin
         slot_q <= 1'b0;
         hold_q <= '0;
      end else begin
         slot_q <= slot;
         if (slot_q) hold_q <= vram_rdata;
      end
   end

   pixel_shifter u_shifter (
      .clk       (clk25175KHz),
      .rst_n     (reset),
      .load      (load),
      .load_data (hold_q),
      .pixel     (pixel)
   );

   // Registered pixel, blanked outside the active area.
   always_ff @(posedge clk25175KHz or negedge reset) begin
      if (!reset) rgb_q <= 3'b000;
      else        rgb_q <= active ? pixel : 3'b000;
   end

   assign redOut   = rgb_q[2];
   assign greenOut = rgb_q[1];
   assign blueOut  = rgb_q[0];

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a VRAM model and a CPU-ack scoreboard.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  hcount = '0, vcount = '0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [14:0] cpu_addr = '0;
   logic [11:0] cpu_wdata = '0;
   logic        cpu_ack;
   logic [11:0] cpu_rdata;
   logic [14:0] vram_addr;
   logic        vram_we;
   logic [11:0] vram_wdata, vram_rdata;
   logic        red, green, blue;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        chk;
      logic [11:0] data;
   } exp_t;
   exp_t exp_q[$];

   logic [11:0] mem [0:32767];

   always #20 clk = ~clk;

   vram_arbiter dut (
      .clk25175KHz (clk),
      .reset       (rst_n),
      .hcount      (hcount),
      .vcount      (vcount),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_ack     (cpu_ack),
      .cpu_rdata   (cpu_rdata),
      .vram_addr   (vram_addr),
      .vram_we     (vram_we),
      .vram_wdata  (vram_wdata),
      .vram_rdata  (vram_rdata),
      .redOut      (red),
      .greenOut    (green),
      .blueOut     (blue)
   );

   // Single-port synchronous-read RAM model
   always @(posedge clk) begin
      if (vram_we) mem[vram_addr] <= vram_wdata;
      vram_rdata <= mem[vram_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every ack consumes one expected transaction
   always @(negedge clk) begin
      if (cpu_ack === 1'b1) begin
         check("ack_pending", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk) check("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
         end
      end
   end

   task automatic next(input int h, input int v);
      @(posedge clk);
      #1;
      hcount = 10'(h);
      vcount = 10'(v);
   endtask

   // Hold a request on a blanking line until acked (bounded), then drop it.
   task automatic cpu_op(input logic we, input int addr, input logic [11:0] wd,
                         input int h0, output logic we_seen);
      logic got;
      int   h;
      got = 1'b0;
      we_seen = 1'b0;
      h = h0;
      next(h, 10);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = 15'(addr); cpu_wdata = wd;
      for (int i = 0; i < 6 && !got; i++) begin
         if (i > 0) begin
            h++;
            next(h, 10);
         end
         @(negedge clk);
         we_seen |= vram_we;
         if (cpu_ack) got = 1'b1;
      end
      check("cpu_op_acked", 32'(got), 1);
      h++;
      next(h, 10);
      cpu_req = 1'b0;
      @(negedge clk);
   endtask

   logic [2:0] exp_rgb [8] = '{3'b100, 3'b100, 3'b010, 3'b010,
                               3'b001, 3'b001, 3'b111, 3'b111};

   initial begin
      int   bad;
      logic we_seen;

      for (int i = 0; i < 32768; i++) mem[i] = '0;
      mem[0]     = 12'h88F;
      mem[7]     = 12'h5A5;
      mem[79]    = 12'hFFF;
      mem[19199] = 12'h321;

      // Reset held for 5 cycles
      for (int i = 0; i < 5; i++) next(i, 0);
      @(negedge clk);
      check("rst_ack", 32'(cpu_ack), 0);
      check("rst_rdata", 32'(cpu_rdata), 0);
      check("rst_rgb", 32'({red, green, blue}), 0);
      check("rst_vram", 32'({vram_we, vram_addr}), 0);
      next(5, 0);
      rst_n = 1'b1;

      // Vertical blank with no CPU traffic
      bad = 0;
      for (int h = 6; h < 800; h++) begin
         next(h, 0);
         @(negedge clk);
         if (vram_we !== 1'b0 || {red, green, blue} !== 3'b000 || cpu_ack !== 1'b0) bad++;
      end
      check("vblank_quiet", 32'(bad), 0);

      // CPU write addr 5 = 0xABC at vcount 10
      next(100, 10);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd5; cpu_wdata = 12'hABC;
      exp_q.push_back('{chk: 1'b0, data: 12'h000});
      @(negedge clk);
      check("wr_access_addr", 32'(vram_addr), 5);
      check("wr_access_we", 32'(vram_we), 1);
      check("wr_access_wdata", 32'(vram_wdata), 32'h0ABC);
      check("wr_access_noack", 32'(cpu_ack), 0);
      next(101, 10);
      @(negedge clk);
      check("wr_ack", 32'(cpu_ack), 1);
      check("wr_ack_no_grant", 32'(vram_we), 0);
      next(102, 10);
      cpu_req = 1'b0;
      @(negedge clk);
      check("wr_ack_one_cycle", 32'(cpu_ack), 0);

      // First active line: fetch at 136 and pixels from VRAM[0] = 0x88F
      for (int h = 130; h <= 160; h++) begin
         next(h, 35);
         @(negedge clk);
         if (h == 136) check("fetch_v35_h136", 32'(vram_addr), 0);
         if (h == 144) check("rgb_before_active", 32'({red, green, blue}), 0);
         if (h >= 145 && h <= 152)
            check($sformatf("rgb_h%0d", h - 1), 32'({red, green, blue}), 32'(exp_rgb[h - 145]));
      end

      // End of line: last fetch at 768 (VRAM[79] = 0xFFF), blank from 784
      for (int h = 760; h <= 790; h++) begin
         next(h, 35);
         @(negedge clk);
         if (h == 768) check("fetch_last_h768", 32'(vram_addr), 79);
         if (h == 776) check("no_slot_h776", 32'(vram_addr), 0);
         if (h == 784) check("rgb_h783", 32'({red, green, blue}), 32'(3'b111));
         if (h == 785) check("rgb_h784_blank", 32'({red, green, blue}), 0);
      end

      // Display address generation at line boundaries
      next(136, 37);  @(negedge clk); check("fetch_v37", 32'(vram_addr), 80);
      next(136, 36);  @(negedge clk); check("fetch_v36", 32'(vram_addr), 0);
      next(144, 36);  @(negedge clk); check("fetch_v36_k1", 32'(vram_addr), 1);
      next(144, 38);  @(negedge clk); check("fetch_v38_k1", 32'(vram_addr), 81);
      next(768, 514); @(negedge clk); check("fetch_max", 32'(vram_addr), 19199);
      next(136, 515); @(negedge clk); check("no_slot_v515", 32'(vram_addr), 0);
      next(136, 34);  @(negedge clk); check("no_slot_v34", 32'(vram_addr), 0);
      next(128, 35);  @(negedge clk); check("no_slot_h128", 32'(vram_addr), 0);

      // CPU read of 7 colliding with the slot at 136
      next(136, 35);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd7;
      exp_q.push_back('{chk: 1'b1, data: 12'h5A5});
      @(negedge clk);
      check("collide_display_wins", 32'(vram_addr), 0);
      next(137, 35);
      @(negedge clk);
      check("collide_access_addr", 32'(vram_addr), 7);
      check("collide_access_rd", 32'(vram_we), 0);
      next(138, 35);
      @(negedge clk);
      check("collide_ack_h138", 32'(cpu_ack), 1);
      next(139, 35);
      cpu_req = 1'b0;
      @(negedge clk);
      check("collide_ack_done", 32'(cpu_ack), 0);

      // Read-back of the earlier write and the in-range boundary word
      exp_q.push_back('{chk: 1'b1, data: 12'hABC});
      cpu_op(1'b0, 5, 12'h000, 200, we_seen);
      exp_q.push_back('{chk: 1'b1, data: 12'h321});
      cpu_op(1'b0, 19199, 12'h000, 220, we_seen);

      // Out-of-range write and read
      exp_q.push_back('{chk: 1'b0, data: 12'h000});
      cpu_op(1'b1, 19200, 12'h777, 240, we_seen);
      check("oor_write_no_we", 32'(we_seen), 0);
      exp_q.push_back('{chk: 1'b1, data: 12'h000});
      cpu_op(1'b0, 19200, 12'h000, 260, we_seen);

      // Reset during ACCESS aborts without an ack
      next(300, 10);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd7;
      @(negedge clk);
      check("abort_access_addr", 32'(vram_addr), 7);
      rst_n = 1'b0;
      next(301, 10);
      cpu_req = 1'b0;
      @(negedge clk);
      check("abort_no_ack", 32'(cpu_ack), 0);
      next(302, 10);
      rst_n = 1'b1;
      bad = 0;
      for (int h = 303; h < 310; h++) begin
         next(h, 10);
         @(negedge clk);
         if (cpu_ack !== 1'b0) bad++;
      end
      check("abort_stays_quiet", 32'(bad), 0);

      check("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbitrates a single-port, synchronous-read video RAM between the display pixel fetch and a CPU read/write port, and drives the RGB pixel outputs. Sits between the VGA timing generator (consumes its `hcount`/`vcount`) and the DAC pins. The framebuffer is 320x240 at 3 bpp and is scaled 2x in each direction to 640x480. The display has fixed priority; the CPU gets every free RAM cycle.

## Interface
- `H_ACTIVE_START`, 144, first active `hcount`
- `V_ACTIVE_START`, 35, first active `vcount`
- `ADDR_W`, 15, VRAM word-address width
- `DATA_W`, 12, VRAM word width (4 pixels × RGB)

Ports:
- `clk25175KHz` in 1: pixel clock. Only clock.
- `reset` in 1: asynchronous, active-low.
- `hcount` in 10, `vcount` in 10: from the timing generator, range 0..799 / 0..524.
- `cpu_req` in 1: held high until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W; `cpu_wdata` in DATA_W.
- `cpu_ack` out 1: single-cycle completion pulse.
- `cpu_rdata` out DATA_W: read data, valid while `cpu_ack` = 1.
- `vram_addr` out ADDR_W, `vram_we` out 1, `vram_wdata` out DATA_W: combinational RAM request for the current cycle.
- `vram_rdata` in DATA_W: valid one cycle after `vram_addr`.
- `redOut`, `greenOut`, `blueOut` out 1 each: registered pixel.

## Operation
- Active area: `hcount` in [H_ACTIVE_START, H_ACTIVE_START+639] and `vcount` in [V_ACTIVE_START, V_ACTIVE_START+479].
- Word packing: pixel 0 is in [11:9], pixel 3 is in [2:0]. Bit order within each pixel is R, G, B, MSB first.
- Display slot: on active lines, the cycles with `hcount` = H_ACTIVE_START−8+8k, k = 0..79.
  - Address = `line`·80 + k, where `line` = (`vcount`−V_ACTIVE_START)>>1.
  - ·80 is computed as (line<<6)+(line<<4). Maximum address is 19199.
- Fetched data is captured into a holding register the cycle after the slot. It is loaded into the shifter at `hcount` = H_ACTIVE_START+8k.
- The shifter presents each pixel for 2 clocks.
- Outside the active area, RGB = 000.
- CPU FSM:
  - IDLE → ACCESS when `cpu_req`=1 and the current cycle is not a display slot. The RAM is driven from the CPU fields in this cycle.
  - ACCESS → ACK, unconditionally.
  - ACK → IDLE. `cpu_ack`=1 in ACK; no CPU grant is made in ACK.
  - The IDLE→ACCESS decision is combinational on `cpu_req` and the slot, so the grant cycle is the ACCESS cycle.
- `cpu_rdata` = `vram_rdata` captured in the ACK cycle.
- Collision with a display slot: the display wins and the CPU stays in IDLE. CPU latency is therefore ≤ 3 cycles.
- `cpu_addr` ≥ 19200:
  - write → `vram_we` stays 0, still acked;
  - read → `cpu_rdata` = 0, still acked.
- No slot is granted and the RAM is idle: `vram_we`=0 and `vram_addr`=0.

## Timing
- Reset (`reset`=0): FSM → IDLE; `cpu_ack`, `cpu_rdata`, RGB, holding register and shifter all → 0.
- Reset mid-access aborts without an ack. The CPU must re-request.
- RGB latency: the pixel for `hcount`=h is on the outputs in the cycle after `hcount`=h is presented.
- Last fetch is at `hcount` 768. The last pixel is for `hcount` 783; RGB is 0 from 784 onward.
- `vcount` wrap (524→0) and `hcount` wrap (799→0) need no special handling. Slots are pure functions of the counts.
- CPU throughput: at most one access per 2 cycles, i.e. ACCESS then ACK.

## Structure
- Shared package `vga_pkg`:
  - H_TOTAL=800, V_TOTAL=525, H_ACTIVE=640, V_ACTIVE=480;
  - H_ACTIVE_START, V_ACTIVE_START;
  - FB_WORDS_PER_LINE=80, FB_WORDS=19200;
  - CPU FSM state enum.
- One sub-module, `pixel_shifter`: takes a 12-bit load and a load strobe, outputs a 3-bit pixel, and advances every 2 clocks.

## Test plan
- Reset held low for 5 cycles → all outputs 0. After release with no `cpu_req` → `vram_we`=0 and RGB=000 throughout vertical blank.
- CPU write, addr 5, data 0xABC, at `vcount`=10 → ACCESS cycle has `vram_addr`=5, `vram_we`=1, `vram_wdata`=0xABC; `cpu_ack` is high for exactly the next cycle.
- VRAM[0]=0x88F, `vcount`=35 → `vram_addr`=0 at `hcount`=136. RGB follows, one cycle after each `hcount`:
  - 100 for 144–145;
  - 010 for 146–147;
  - 001 for 148–149;
  - 111 for 150–151.
- `vcount`=37 → the fetch at `hcount`=136 uses address 80. `vcount`=36 → address 0.
- `cpu_req` read of addr 7 rising at `hcount`=136 on an active line → RAM goes to the display at 136, CPU ACCESS at 137, `cpu_ack` at 138 with `cpu_rdata`=VRAM[7].
- Write to addr 19200 → `vram_we` never 1 and ack still given. Read of 19200 → `cpu_rdata`=0. `reset` low during ACCESS → no `cpu_ack`.
